// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: iterative AES round sequencer.
// Accepts one block per in_valid/in_ready handshake, loads round 0 through the
// AddRoundKey path, steps rounds 1..NR through the round function, then holds
// the result with out_valid until the consumer takes it.
// Optional build macro: AES_ROUND_CTRL_ABORT_EN adds the abort input, which
// cancels a block that is in its round phase.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   S_IDLE  | waiting for a block; round 0 load happens on the handshake
//   S_ROUND | loading round cnt_q (1..NR) into the state register
//   S_DONE  | ciphertext held in the state register, out_valid asserted
module aes_round_ctrl #(
  parameter int unsigned NR = 10,
  parameter int unsigned RW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
`ifdef AES_ROUND_CTRL_ABORT_EN
  input  logic          abort,
`endif
  input  logic          in_valid,
  output logic          in_ready,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          st_en,
  output logic          st_sel,
  output logic          final_rnd,
  output logic [RW-1:0] round_idx,
  output logic          busy
);

  // Only the three standard AES key sizes are meaningful, and the counter
  // must be able to hold NR without wrapping.
  if (!(NR == 10 || NR == 12 || NR == 14)) begin : g_bad_nr
    $error("aes_round_ctrl: NR must be 10, 12 or 14");
  end
  if ((2 ** RW) <= NR) begin : g_bad_rw
    $error("aes_round_ctrl: RW too narrow for NR");
  end

  localparam logic [RW-1:0] NR_W = RW'(NR);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROUND = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t        state_q;
  logic [RW-1:0] cnt_q;
  logic          abort_w;

`ifdef AES_ROUND_CTRL_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  // Sequencer: state and round counter; reset wins over abort.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            cnt_q   <= RW'(1);
            state_q <= S_ROUND;
          end
        end
        S_ROUND: begin
          if (abort_w) begin
            cnt_q   <= '0;
            state_q <= S_IDLE;
          end else if (cnt_q == NR_W) begin
            cnt_q   <= '0;
            state_q <= S_DONE;
          end else begin
            cnt_q <= cnt_q + RW'(1);
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state_q <= S_IDLE;
          end
        end
        default: begin
          cnt_q   <= '0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Output decode from state/count; everything is forced low while in reset.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    st_en     = 1'b0;
    st_sel    = 1'b0;
    final_rnd = 1'b0;
    round_idx = '0;
    busy      = 1'b0;
    if (rst_n) begin
      case (state_q)
        S_IDLE: begin
          in_ready = 1'b1;
          st_en    = in_valid;
        end
        S_ROUND: begin
          st_en     = !abort_w;
          st_sel    = 1'b1;
          round_idx = cnt_q;
          final_rnd = (cnt_q == NR_W);
          busy      = 1'b1;
        end
        S_DONE: begin
          out_valid = 1'b1;
          busy      = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Testbench for aes_round_ctrl: cycle-by-cycle comparison against a timeline
// model (cycles since accept) for NR=10 and NR=14 instances.
module tb_aes_round_ctrl;

`ifdef AES_ROUND_CTRL_ABORT_EN
  localparam bit ABT = 1'b1;
`else
  localparam bit ABT = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0;
  logic iv = 1'b0, ordy = 1'b0, ab = 1'b0;
  logic iv14 = 1'b0, ordy14 = 1'b1;

  logic in_ready, out_valid, st_en, st_sel, final_rnd, busy;
  logic [3:0] round_idx;
  logic in_ready14, out_valid14, st_en14, st_sel14, final_rnd14, busy14;
  logic [3:0] round_idx14;

  aes_round_ctrl #(.NR(10), .RW(4)) dut (
    .clk(clk), .rst_n(rst_n),
`ifdef AES_ROUND_CTRL_ABORT_EN
    .abort(ab),
`endif
    .in_valid(iv), .in_ready(in_ready), .out_valid(out_valid),
    .out_ready(ordy), .st_en(st_en), .st_sel(st_sel),
    .final_rnd(final_rnd), .round_idx(round_idx), .busy(busy)
  );

  aes_round_ctrl #(.NR(14), .RW(4)) dut14 (
    .clk(clk), .rst_n(rst_n),
`ifdef AES_ROUND_CTRL_ABORT_EN
    .abort(1'b0),
`endif
    .in_valid(iv14), .in_ready(in_ready14), .out_valid(out_valid14),
    .out_ready(ordy14), .st_en(st_en14), .st_sel(st_sel14),
    .final_rnd(final_rnd14), .round_idx(round_idx14), .busy(busy14)
  );

  logic [9:0] obs10, obs14;
  assign obs10 = {in_ready, out_valid, st_en, st_sel, final_rnd, busy, round_idx};
  assign obs14 = {in_ready14, out_valid14, st_en14, st_sel14, final_rnd14, busy14, round_idx14};

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int p10 = 0;   // 0 idle, k in 1..NR round k, NR+1 done
  int p14 = 0;
  logic [9:0] e;

  always @(posedge clk) cyc++;

  // Expected outputs given the block's position on its timeline.
  function automatic logic [9:0] exp_vec(int nr, int p, logic rn, logic iv_, logic ab_);
    logic [9:0] v;
    v = '0;
    if (!rn) return v;
    if (p == 0) begin
      v[9] = 1'b1;
      v[7] = iv_;
    end else if (p <= nr) begin
      v[7] = !(ABT && ab_);
      v[6] = 1'b1;
      v[5] = (p == nr);
      v[4] = 1'b1;
      v[3:0] = p[3:0];
    end else begin
      v[8] = 1'b1;
      v[4] = 1'b1;
    end
    return v;
  endfunction

  function automatic int next_p(int nr, int p, logic rn, logic iv_, logic ordy_, logic ab_);
    if (!rn) return 0;
    if (p == 0) return iv_ ? 1 : 0;
    if (p <= nr) return (ABT && ab_) ? 0 : p + 1;
    return ordy_ ? 0 : nr + 1;
  endfunction

  task automatic drive(input logic rn, input logic iv_, input logic ordy_, input logic ab_);
    @(negedge clk);
    rst_n = rn; iv = iv_; ordy = ordy_; ab = ab_;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    p10 = next_p(10, p10, rst_n, iv, ordy, ab);
    p14 = next_p(14, p14, rst_n, iv14, ordy14, 1'b0);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, i[0], 1'b1, 1'b0);
      e = exp_vec(10, p10, rst_n, iv, ab);
      n_checks++;
      if (obs10 !== e) begin
        n_errors++;
        $display("FAIL reset_low cyc=%0d got=%b exp=%b", cyc, obs10, e);
      end
      tick();
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (obs10 !== 10'b10_0000_0000) begin
      n_errors++;
      $display("FAIL reset_idle got=%b exp=%b", obs10, 10'b10_0000_0000);
    end
    tick();
  endtask

  task automatic test_single();
    int t0, first_ov, finals;
    t0 = -1; first_ov = -1; finals = 0;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, (i == 0), (i == 14), 1'b0);
      if (i == 0) t0 = cyc;
      if (out_valid && first_ov < 0) first_ov = cyc;
      if (final_rnd) finals++;
      e = exp_vec(10, p10, rst_n, iv, ab);
      n_checks++;
      if (obs10 !== e) begin
        n_errors++;
        $display("FAIL single cyc=%0d got=%b exp=%b", cyc, obs10, e);
      end
      tick();
    end
    n_checks++;
    if (first_ov - t0 !== 11) begin
      n_errors++;
      $display("FAIL single_ov_latency got=%0d exp=11", first_ov - t0);
    end
    n_checks++;
    if (finals !== 1) begin
      n_errors++;
      $display("FAIL single_final_count got=%0d exp=1", finals);
    end
  endtask

  task automatic test_backpressure();
    int done_cnt, ov_cnt;
    bit released;
    done_cnt = 0; ov_cnt = 0; released = 0;
    for (int i = 0; i < 40 && !(released && p10 == 0); i++) begin
      drive(1'b1, !released, (done_cnt >= 7), 1'b0);
      if (out_valid) ov_cnt++;
      e = exp_vec(10, p10, rst_n, iv, ab);
      n_checks++;
      if (obs10 !== e) begin
        n_errors++;
        $display("FAIL backpressure cyc=%0d got=%b exp=%b", cyc, obs10, e);
      end
      if (p10 == 11) begin
        if (done_cnt >= 7) released = 1;
        done_cnt++;
      end
      tick();
    end
    n_checks++;
    if (ov_cnt !== 8) begin
      n_errors++;
      $display("FAIL backpressure_hold got=%0d exp=8", ov_cnt);
    end
  endtask

  task automatic test_back_to_back();
    int accepts, finals, ovs, last_acc, bad_gap;
    accepts = 0; finals = 0; ovs = 0; last_acc = -1; bad_gap = 0;
    for (int i = 0; i < 48; i++) begin
      drive(1'b1, 1'b1, 1'b1, 1'b0);
      if (in_ready && iv) begin
        if (last_acc >= 0 && cyc - last_acc != 12) bad_gap++;
        last_acc = cyc;
        accepts++;
      end
      if (final_rnd) finals++;
      if (out_valid) ovs++;
      e = exp_vec(10, p10, rst_n, iv, ab);
      n_checks++;
      if (obs10 !== e) begin
        n_errors++;
        $display("FAIL b2b cyc=%0d got=%b exp=%b", cyc, obs10, e);
      end
      tick();
    end
    n_checks++;
    if (accepts !== 4 || bad_gap !== 0) begin
      n_errors++;
      $display("FAIL b2b_accepts got=%0d gaps_bad=%0d exp=4 gaps_bad=0", accepts, bad_gap);
    end
    n_checks++;
    if (finals !== 4 || ovs !== 4) begin
      n_errors++;
      $display("FAIL b2b_counts finals=%0d ovs=%0d exp=4,4", finals, ovs);
    end
  endtask

  task automatic test_reset_mid();
    int ovs;
    ovs = 0;
    for (int i = 0; i < 22; i++) begin
      drive(!(i >= 4 && i <= 6), (i == 0), 1'b1, 1'b0);
      if (out_valid) ovs++;
      e = exp_vec(10, p10, rst_n, iv, ab);
      n_checks++;
      if (obs10 !== e) begin
        n_errors++;
        $display("FAIL reset_mid cyc=%0d got=%b exp=%b", cyc, obs10, e);
      end
      tick();
    end
    n_checks++;
    if (ovs !== 0) begin
      n_errors++;
      $display("FAIL reset_mid_ov got=%0d exp=0", ovs);
    end
  endtask

  task automatic test_nr14();
    int t0, t_final, t_ov, max_idx;
    t0 = -1; t_final = -1; t_ov = -1; max_idx = 0;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      rst_n = 1'b1; iv = 1'b0; ordy = 1'b1; ab = 1'b0;
      iv14 = (i == 0); ordy14 = 1'b1;
      #1;
      if (i == 0) t0 = cyc;
      if (final_rnd14 && t_final < 0) t_final = cyc;
      if (out_valid14 && t_ov < 0) t_ov = cyc;
      if (int'(round_idx14) > max_idx) max_idx = int'(round_idx14);
      e = exp_vec(14, p14, rst_n, iv14, 1'b0);
      n_checks++;
      if (obs14 !== e) begin
        n_errors++;
        $display("FAIL nr14 cyc=%0d got=%b exp=%b", cyc, obs14, e);
      end
      tick();
    end
    iv14 = 1'b0;
    n_checks++;
    if (max_idx !== 14 || t_final - t0 !== 14 || t_ov - t0 !== 15) begin
      n_errors++;
      $display("FAIL nr14_timing idx=%0d final=%0d ov=%0d exp=14,14,15", max_idx, t_final - t0, t_ov - t0);
    end
  endtask

`ifdef AES_ROUND_CTRL_ABORT_EN
  task automatic test_abort();
    int ovs;
    ovs = 0;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, (i == 0), 1'b1, (i == 4));
      if (out_valid) ovs++;
      e = exp_vec(10, p10, rst_n, iv, ab);
      n_checks++;
      if (obs10 !== e) begin
        n_errors++;
        $display("FAIL abort cyc=%0d got=%b exp=%b", cyc, obs10, e);
      end
      tick();
    end
    n_checks++;
    if (ovs !== 0) begin
      n_errors++;
      $display("FAIL abort_ov got=%0d exp=0", ovs);
    end
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(($urandom % 40) != 0, $urandom % 2 == 1, ($urandom % 3) != 0, ($urandom % 8) == 0);
      e = exp_vec(10, p10, rst_n, iv, ab);
      n_checks++;
      if (obs10 !== e) begin
        n_errors++;
        $display("FAIL random cyc=%0d got=%b exp=%b", cyc, obs10, e);
      end
      tick();
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && p10 != 0; i++) begin
      drive(1'b1, 1'b0, 1'b1, 1'b0);
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    drain();
    test_backpressure();
    drain();
    test_back_to_back();
    drain();
    test_reset_mid();
    test_nr14();
`ifdef AES_ROUND_CTRL_ABORT_EN
    test_abort();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
